pipelined_adder: RTL

Parametrised, pipelined ripple-carry adder; the next-generation replacement for the fixed 4-bit combinational adder. It splits a WIDTH-bit addition into STAGES equal chunks, one chunk per clock, with the carry registered between stages. A valid/ready handshake on both sides lets it sit between datapath blocks that can stall. The pipeline sustains one result per cycle.

---
 rtl/pipelined_adder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit ripple-carry add split into STAGES registered chunks,
// valid/ready on both sides, global stall. Define OVERFLOW_EN to add signed-overflow output V.

module pipelined_adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
endmodule

module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_out
`ifdef OVERFLOW_EN
  ,
  output logic             V
`endif
);
  localparam int CHUNK = WIDTH / STAGES;

  logic            advance;
  logic [STAGES:0] vld_pipe;

  // One stall signal freezes every stage; in_ready is the only comb path from out_ready.
  assign advance     = !out_valid || out_ready;
  assign in_ready    = advance;
  assign vld_pipe[0] = in_valid;
  assign out_valid   = vld_pipe[STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          vld_pipe[STAGES:1] <= '0;
    else if (advance) vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int HI = LO + CHUNK;

    logic [CHUNK-1:0] a_c, b_c, s_c;
    logic             ci, co;
    logic [HI-1:0]    s_nx, s_q;
    logic             c_q;

    if (k == 0) begin : g_src
      assign a_c  = A[CHUNK-1:0];
      assign b_c  = B[CHUNK-1:0];
      assign ci   = C_in;
      assign s_nx = s_c;
    end else begin : g_src
      assign a_c  = g_stage[k-1].g_ops.a_q[CHUNK-1:0];
      assign b_c  = g_stage[k-1].g_ops.b_q[CHUNK-1:0];
      assign ci   = g_stage[k-1].c_q;
      assign s_nx = {s_c, g_stage[k-1].s_q};
    end

    pipelined_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a  (a_c),
      .b  (b_c),
      .ci (ci),
      .s  (s_c),
      .co (co)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (advance) begin
        s_q <= s_nx;
        c_q <= co;
      end
    end

    // Operand skew: only the not-yet-consumed upper chunks travel forward.
    if (k < STAGES - 1) begin : g_ops
      localparam int REM = WIDTH - HI;
      logic [REM-1:0] a_rem, b_rem, a_q, b_q;

      if (k == 0) begin : g_rem
        assign a_rem = A[WIDTH-1:HI];
        assign b_rem = B[WIDTH-1:HI];
      end else begin : g_rem
        assign a_rem = g_stage[k-1].g_ops.a_q[REM+CHUNK-1:CHUNK];
        assign b_rem = g_stage[k-1].g_ops.b_q[REM+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_rem;
          b_q <= b_rem;
        end
      end
    end
  end

  assign S     = g_stage[STAGES-1].s_q;
  assign C_out = g_stage[STAGES-1].c_q;

`ifdef OVERFLOW_EN
  // Operand sign bits ride the skew registers up to the last chunk, where V is resolved.
  logic a_msb, b_msb, s_msb, v_q;

  assign a_msb = g_stage[STAGES-1].a_c[CHUNK-1];
  assign b_msb = g_stage[STAGES-1].b_c[CHUNK-1];
  assign s_msb = g_stage[STAGES-1].s_c[CHUNK-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          v_q <= 1'b0;
    else if (advance) v_q <= (a_msb == b_msb) && (s_msb != a_msb);
  end

  assign V = v_q;
`endif
endmodule
